// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FWFT FIFO with fill level, almost flags, flush.
// Optional stats outputs (high_water, drop_count) under SYNC_FIFO_FLEX_STATS_EN.
module sync_fifo_flex #(
    parameter int data_width         = 8,
    parameter int depth              = 16,
    parameter int almost_full_level  = 14,
    parameter int almost_empty_level = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [data_width-1:0]        write_data,
    input  logic                         write_valid,
    output logic                         write_ready,
    output logic [data_width-1:0]        read_data,
    output logic                         read_valid,
    input  logic                         read_ack,
    output logic [$clog2(depth+1)-1:0]   fill_level,
    output logic                         almost_full,
`ifdef SYNC_FIFO_FLEX_STATS_EN
    output logic [$clog2(depth+1)-1:0]   high_water,
    output logic [15:0]                  drop_count,
`endif
    output logic                         almost_empty
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(depth);
    localparam logic [CW-1:0] AF_C    = CW'(almost_full_level);
    localparam logic [CW-1:0] AE_C    = CW'(almost_empty_level);
    localparam logic [PW-1:0] LAST_C  = PW'(depth - 1);

    if (depth < 2) begin : g_bad_depth
        $error("sync_fifo_flex: depth must be >= 2");
    end
    if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_af
        $error("sync_fifo_flex: almost_full_level out of range");
    end
    if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ae
        $error("sync_fifo_flex: almost_empty_level out of range");
    end

    logic [data_width-1:0] r_mem [depth];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [CW-1:0]         w_count_nxt;

    assign write_ready  = (r_count != DEPTH_C) && !flush;
    assign read_valid   = (r_count != '0) && !flush;
    assign read_data    = r_mem[r_rptr];
    assign fill_level   = r_count;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

    assign w_wr_en = write_valid && write_ready;
    assign w_rd_en = read_valid && read_ack;

    // Next fill count; flush overrides any transfer.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_en && w_rd_en) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= write_data;
        end
    end

    // Pointers, count and threshold flags derived from next count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
        end else begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wptr <= (r_wptr == LAST_C) ? '0 : r_wptr + 1'b1;
                end
                if (w_rd_en) begin
                    r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + 1'b1;
                end
            end
            r_count <= w_count_nxt;
            r_af    <= (w_count_nxt >= AF_C);
            r_ae    <= (w_count_nxt <= AE_C);
        end
    end

`ifdef SYNC_FIFO_FLEX_STATS_EN
    logic [CW-1:0] r_high_water;
    logic [15:0]   r_drop_count;
    logic          w_drop;

    assign w_drop     = write_valid && !write_ready && !flush;
    assign high_water = r_high_water;
    assign drop_count = r_drop_count;

    // Peak occupancy tracker; flush restarts it, drops survive flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_high_water <= '0;
            r_drop_count <= '0;
        end else begin
            if (flush) begin
                r_high_water <= '0;
            end else if (w_count_nxt > r_high_water) begin
                r_high_water <= w_count_nxt;
            end
            if (w_drop && r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed checks of sync_fifo_flex at depth 5.
// Stats outputs are checked when SYNC_FIFO_FLEX_STATS_EN is defined.
module tb_sync_fifo_flex;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic [7:0] write_data;
    logic       write_valid;
    logic       write_ready;
    logic [7:0] read_data;
    logic       read_valid;
    logic       read_ack;
    logic [2:0] fill_level;
    logic       almost_full;
    logic       almost_empty;
`ifdef SYNC_FIFO_FLEX_STATS_EN
    logic [2:0]  high_water;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    sync_fifo_flex #(
        .data_width(8),
        .depth(5),
        .almost_full_level(4),
        .almost_empty_level(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .write_data(write_data),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .read_data(read_data),
        .read_valid(read_valid),
        .read_ack(read_ack),
        .fill_level(fill_level),
        .almost_full(almost_full),
`ifdef SYNC_FIFO_FLEX_STATS_EN
        .high_water(high_water),
        .drop_count(drop_count),
`endif
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush = 1'b0;
        write_data = '0;
        write_valid = 1'b0;
        read_ack = 1'b0;
        #12;
        checks++;
        if (write_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wready got %b exp 1", write_ready);
        end
        checks++;
        if (read_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_rvalid got %b exp 0", read_valid);
        end
        checks++;
        if (fill_level !== 3'd0) begin
            errors++;
            $display("FAIL rst_fill got %0d exp 0", fill_level);
        end
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_flags got af=%b ae=%b exp 0/1",
                     almost_full, almost_empty);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            write_valid = 1'b1;
            write_data = 8'h11 + 8'(i);
            cyc();
            checks++;
            if (fill_level !== 3'(i + 1)) begin
                errors++;
                $display("FAIL fill_lvl[%0d] got %0d exp %0d",
                         i, fill_level, i + 1);
            end
            checks++;
            if (almost_full !== (i + 1 >= 4)) begin
                errors++;
                $display("FAIL fill_af[%0d] got %b exp %b",
                         i, almost_full, (i + 1 >= 4));
            end
            checks++;
            if (almost_empty !== (i + 1 <= 1)) begin
                errors++;
                $display("FAIL fill_ae[%0d] got %b exp %b",
                         i, almost_empty, (i + 1 <= 1));
            end
            checks++;
            if (write_ready !== (i != 4)) begin
                errors++;
                $display("FAIL fill_wready[%0d] got %b exp %b",
                         i, write_ready, (i != 4));
            end
            checks++;
            if (read_valid !== 1'b1 || read_data !== 8'h11) begin
                errors++;
                $display("FAIL fill_head[%0d] got %b/%h exp 1/11",
                         i, read_valid, read_data);
            end
        end
`ifdef SYNC_FIFO_FLEX_STATS_EN
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL drop_pre got %0d exp 0", drop_count);
        end
`endif
        write_data = 8'h16;
        cyc();
        checks++;
        if (fill_level !== 3'd5 || write_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got %0d/%b exp 5/0",
                     fill_level, write_ready);
        end
`ifdef SYNC_FIFO_FLEX_STATS_EN
        checks++;
        if (drop_count !== 16'd1) begin
            errors++;
            $display("FAIL drop_one got %0d exp 1", drop_count);
        end
`endif
        write_valid = 1'b0;
    endtask

    task automatic test_drain();
        read_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (read_valid !== 1'b1 || read_data !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL drain_data[%0d] got %b/%h exp 1/%h",
                         i, read_valid, read_data, 8'h11 + 8'(i));
            end
            cyc();
            checks++;
            if (fill_level !== 3'(4 - i)) begin
                errors++;
                $display("FAIL drain_lvl[%0d] got %0d exp %0d",
                         i, fill_level, 4 - i);
            end
            checks++;
            if (almost_empty !== (4 - i <= 1) ||
                almost_full !== (4 - i >= 4)) begin
                errors++;
                $display("FAIL drain_flags[%0d] got af=%b ae=%b",
                         i, almost_full, almost_empty);
            end
        end
        checks++;
        if (read_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got %b exp 0", read_valid);
        end
        cyc();
        checks++;
        if (fill_level !== 3'd0) begin
            errors++;
            $display("FAIL ack_empty got %0d exp 0", fill_level);
        end
        read_ack = 1'b0;
    endtask

    task automatic test_wrap();
        write_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_data = 8'h20 + 8'(i);
            cyc();
        end
        checks++;
        if (fill_level !== 3'd3) begin
            errors++;
            $display("FAIL wrap_prime got %0d exp 3", fill_level);
        end
        read_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            write_data = 8'h23 + 8'(i);
            #1;
            checks++;
            if (read_data !== 8'h20 + 8'(i)) begin
                errors++;
                $display("FAIL wrap_data[%0d] got %h exp %h",
                         i, read_data, 8'h20 + 8'(i));
            end
            cyc();
            checks++;
            if (fill_level !== 3'd3 || almost_full !== 1'b0 ||
                almost_empty !== 1'b0) begin
                errors++;
                $display("FAIL wrap_lvl[%0d] got %0d af=%b ae=%b exp 3",
                         i, fill_level, almost_full, almost_empty);
            end
        end
        write_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (read_data !== 8'h2C + 8'(i)) begin
                errors++;
                $display("FAIL wrap_tail[%0d] got %h exp %h",
                         i, read_data, 8'h2C + 8'(i));
            end
            cyc();
        end
        read_ack = 1'b0;
        checks++;
        if (fill_level !== 3'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got %0d/%b exp 0/0",
                     fill_level, read_valid);
        end
    endtask

    task automatic test_latency();
        write_valid = 1'b1;
        write_data = 8'hA5;
        #1;
        checks++;
        if (read_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_pre got %b exp 0", read_valid);
        end
        cyc();
        write_valid = 1'b0;
        #1;
        checks++;
        if (read_valid !== 1'b1 || read_data !== 8'hA5) begin
            errors++;
            $display("FAIL lat_vis got %b/%h exp 1/a5",
                     read_valid, read_data);
        end
        read_ack = 1'b1;
        cyc();
        read_ack = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_drain got %0d/%b exp 0/0",
                     fill_level, read_valid);
        end
    endtask

    task automatic test_flush();
        write_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            write_data = 8'h31 + 8'(i);
            cyc();
        end
        checks++;
        if (fill_level !== 3'd4 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre got %0d/%b exp 4/1",
                     fill_level, almost_full);
        end
`ifdef SYNC_FIFO_FLEX_STATS_EN
        checks++;
        if (high_water !== 3'd5) begin
            errors++;
            $display("FAIL hw_pre got %0d exp 5", high_water);
        end
`endif
        flush = 1'b1;
        write_data = 8'h99;
        read_ack = 1'b1;
        #1;
        checks++;
        if (write_ready !== 1'b0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gate got %b/%b exp 0/0",
                     write_ready, read_valid);
        end
        cyc();
        flush = 1'b0;
        write_valid = 1'b0;
        read_ack = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clr got %0d/%b exp 0/0",
                     fill_level, read_valid);
        end
        checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL flush_flags got af=%b ae=%b exp 0/1",
                     almost_full, almost_empty);
        end
`ifdef SYNC_FIFO_FLEX_STATS_EN
        checks++;
        if (high_water !== 3'd0 || drop_count !== 16'd1) begin
            errors++;
            $display("FAIL flush_stats got hw=%0d dc=%0d exp 0/1",
                     high_water, drop_count);
        end
`endif
        write_valid = 1'b1;
        write_data = 8'h40;
        cyc();
        write_valid = 1'b0;
        #1;
        checks++;
        if (read_data !== 8'h40 || fill_level !== 3'd1) begin
            errors++;
            $display("FAIL flush_post got %h/%0d exp 40/1",
                     read_data, fill_level);
        end
        read_ack = 1'b1;
        cyc();
        read_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        write_valid = 1'b1;
        write_data = 8'h50;
        cyc();
        write_data = 8'h51;
        cyc();
        checks++;
        if (fill_level !== 3'd2) begin
            errors++;
            $display("FAIL ar_pre got %0d exp 2", fill_level);
        end
        write_data = 8'h52;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd0 || read_valid !== 1'b0 ||
            write_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_now got %0d/%b/%b exp 0/0/1",
                     fill_level, read_valid, write_ready);
        end
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL ar_flags got af=%b ae=%b exp 0/1",
                     almost_full, almost_empty);
        end
`ifdef SYNC_FIFO_FLEX_STATS_EN
        checks++;
        if (high_water !== 3'd0 || drop_count !== 16'd0) begin
            errors++;
            $display("FAIL ar_stats got hw=%0d dc=%0d exp 0/0",
                     high_water, drop_count);
        end
`endif
        write_valid = 1'b0;
        cyc();
        @(negedge clk);
        reset_n = 1'b1;
        cyc();
        write_valid = 1'b1;
        write_data = 8'h60;
        cyc();
        write_valid = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd1 || read_data !== 8'h60) begin
            errors++;
            $display("FAIL ar_new got %0d/%h exp 1/60",
                     fill_level, read_data);
        end
        read_ack = 1'b1;
        cyc();
        read_ack = 1'b0;
        #1;
        checks++;
        if (fill_level !== 3'd0 || read_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_drain got %0d/%b exp 0/0",
                     fill_level, read_valid);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_latency();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
